// File: rtl/stopwatch_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_datapath
//  Purpose  : Counter/display datapath for the stopwatch/timer. Holds a
//             0..9999 hundredths-of-second count (XX.XX s) that is loaded,
//             cleared, or counted up/down at the TICK rate under controller
//             command. Flags the selected terminal value and drives a 4-digit
//             multiplexed active-low 7-segment display.
//  Ports    : clk            - system clock, rising edge
//             reset          - asynchronous, active-low reset
//             init_ld_en     - capture InitVal into synchInit; allow load
//             count_en       - enable up/down counting
//             ctrSelect[2:0] - 0 load, 1 up, 2 down, 3 clear, 4..7 hold
//             InitVal[16:0]  - binary start value
//             tcSelect       - 0: terminal = MAX_COUNT, 1: terminal = 0
//             anReset        - blank display and restart digit scan
//             tcLimitReached - count equals the selected terminal
//             an[3:0]        - digit anodes, active-low, an[0] = ones
//             sseg[6:0]      - segments active-low, sseg[0]=a .. sseg[6]=g
//             synchInit[16:0]- registered copy of the last captured InitVal
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_datapath #(
    parameter int TICK_DIV  = 1_000_000,
    parameter int SCAN_BITS = 18,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_ld_en,
    input  logic        count_en,
    input  logic [2:0]  ctrSelect,
    input  logic [16:0] InitVal,
    input  logic        tcSelect,
    input  logic        anReset,
    output logic        tcLimitReached,
    output logic [3:0]  an,
    output logic [6:0]  sseg,
    output logic [16:0] synchInit
);

    localparam int               c_pre_w    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [16:0]      c_max      = 17'(MAX_COUNT);
    localparam logic [16:0]      c_one      = 17'd1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);
    localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);
    localparam logic [SCAN_BITS-1:0] c_scan_one = SCAN_BITS'(1);

    localparam logic [2:0] c_sel_load  = 3'd0;
    localparam logic [2:0] c_sel_up    = 3'd1;
    localparam logic [2:0] c_sel_down  = 3'd2;
    localparam logic [2:0] c_sel_clear = 3'd3;

    localparam logic [3:0] c_an_off   = 4'b1111;
    localparam logic [6:0] c_seg_off  = 7'b1111111;

    logic [16:0]          r_count;
    logic [16:0]          r_synch_init;
    logic [c_pre_w-1:0]   r_prescaler;
    logic [SCAN_BITS-1:0] r_scan;
    logic [3:0]           r_an;
    logic [6:0]           r_sseg;

    logic                 w_tick;
    logic [3:0]           w_ones;
    logic [3:0]           w_tens;
    logic [3:0]           w_hundreds;
    logic [3:0]           w_thousands;
    logic [1:0]           w_sel;
    logic [3:0]           w_digit;
    logic [3:0]           w_an_next;

    // Segment pattern for one BCD digit, gfedcba order, active-low.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Initial-value capture register (unclamped; the controller compares
    // it against InitVal to know the load has landed).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_synch_init <= '0;
        end else if (init_ld_en) begin
            r_synch_init <= InitVal;
        end
    end

    // ------------------------------------------------------------------
    // Count register and tick prescaler. The prescaler only advances on
    // enabled counting cycles so a pause preserves the tick phase; load
    // and clear restart it so the first tick is a full TICK_DIV away.
    // ------------------------------------------------------------------
    assign w_tick = (r_prescaler == c_pre_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= '0;
            r_prescaler <= '0;
        end else begin
            case (ctrSelect)
                c_sel_clear: begin
                    r_count     <= '0;
                    r_prescaler <= '0;
                end
                c_sel_load: begin
                    if (init_ld_en) begin
                        r_count     <= (InitVal > c_max) ? c_max : InitVal;
                        r_prescaler <= '0;
                    end
                end
                c_sel_up: begin
                    if (count_en) begin
                        if (w_tick) begin
                            r_prescaler <= '0;
                            if (r_count != c_max) begin
                                r_count <= r_count + c_one;
                            end
                        end else begin
                            r_prescaler <= r_prescaler + c_pre_one;
                        end
                    end
                end
                c_sel_down: begin
                    if (count_en) begin
                        if (w_tick) begin
                            r_prescaler <= '0;
                            if (r_count != '0) begin
                                r_count <= r_count - c_one;
                            end
                        end else begin
                            r_prescaler <= r_prescaler + c_pre_one;
                        end
                    end
                end
                default: begin
                    r_count     <= r_count;
                    r_prescaler <= r_prescaler;
                end
            endcase
        end
    end

    assign tcLimitReached = tcSelect ? (r_count == '0) : (r_count == c_max);
    assign synchInit      = r_synch_init;

    // ------------------------------------------------------------------
    // Binary to BCD. The count never exceeds 9999, so the thousands
    // digit is always a valid decimal digit.
    // ------------------------------------------------------------------
    always_comb begin
        w_ones      = 4'(r_count % 17'd10);
        w_tens      = 4'((r_count / 17'd10) % 17'd10);
        w_hundreds  = 4'((r_count / 17'd100) % 17'd10);
        w_thousands = 4'((r_count / 17'd1000) % 17'd10);
    end

    // ------------------------------------------------------------------
    // Display multiplexing: top two scan bits pick the digit.
    // ------------------------------------------------------------------
    assign w_sel     = r_scan[SCAN_BITS-1 -: 2];
    assign w_an_next = ~(4'b0001 << w_sel);

    always_comb begin
        w_digit = w_ones;
        case (w_sel)
            2'd0:    w_digit = w_ones;
            2'd1:    w_digit = w_tens;
            2'd2:    w_digit = w_hundreds;
            default: w_digit = w_thousands;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan <= '0;
            r_an   <= c_an_off;
            r_sseg <= c_seg_off;
        end else if (anReset) begin
            r_scan <= '0;
            r_an   <= c_an_off;
            r_sseg <= c_seg_off;
        end else begin
            r_scan <= r_scan + c_scan_one;
            r_an   <= w_an_next;
            r_sseg <= seg7(w_digit);
        end
    end

    assign an   = r_an;
    assign sseg = r_sseg;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_datapath
//  Purpose  : Scoreboard bench for stopwatch_datapath. Stimulus pushes the
//             expected observations into a queue; a monitor pops and
//             compares them on the falling clock edge (or on demand for the
//             asynchronous reset case).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_datapath;

    localparam int TICK_DIV  = 4;
    localparam int SCAN_BITS = 4;
    localparam int MAX_COUNT = 9999;

    logic        clk;
    logic        reset;
    logic        init_ld_en;
    logic        count_en;
    logic [2:0]  ctrSelect;
    logic [16:0] InitVal;
    logic        tcSelect;
    logic        anReset;
    logic        tcLimitReached;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic [16:0] synchInit;

    stopwatch_datapath #(
        .TICK_DIV  (TICK_DIV),
        .SCAN_BITS (SCAN_BITS),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .init_ld_en     (init_ld_en),
        .count_en       (count_en),
        .ctrSelect      (ctrSelect),
        .InitVal        (InitVal),
        .tcSelect       (tcSelect),
        .anReset        (anReset),
        .tcLimitReached (tcLimitReached),
        .an             (an),
        .sseg           (sseg),
        .synchInit      (synchInit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {S_COUNT, S_SYNCH, S_TC, S_AN, S_SSEG} sig_e;
    typedef struct {
        sig_e  sig;
        int    exp;
        string name;
    } chk_t;

    chk_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    event ev_sample;

    function automatic int observe(input sig_e s);
        case (s)
            S_COUNT: observe = int'(dut.r_count);
            S_SYNCH: observe = int'(synchInit);
            S_TC:    observe = int'(tcLimitReached);
            S_AN:    observe = int'(an);
            default: observe = int'(sseg);
        endcase
    endfunction

    task automatic expect_val(input sig_e s, input int e, input string nm);
        chk_t c;
        c.sig  = s;
        c.exp  = e;
        c.name = nm;
        sb.push_back(c);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: drains every pending expectation at the sample point.
    initial begin
        forever begin
            @(negedge clk or ev_sample);
            while (sb.size() > 0) begin
                chk_t c;
                int   a;
                c = sb.pop_front();
                a = observe(c.sig);
                n_vec++;
                if (a !== c.exp) begin
                    n_err++;
                    $display("FAIL %s: got %0d expected %0d", c.name, a, c.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b0;
        init_ld_en = 1'b0;
        count_en   = 1'b0;
        ctrSelect  = 3'd4;
        InitVal    = '0;
        tcSelect   = 1'b1;
        anReset    = 1'b0;
        #1;
        expect_val(S_COUNT, 0,   "reset_count");
        expect_val(S_SYNCH, 0,   "reset_synch");
        expect_val(S_AN,    15,  "reset_an");
        expect_val(S_SSEG,  127, "reset_sseg");
        expect_val(S_TC,    1,   "reset_tc_down");
        step(2);
        reset    = 1'b1;
        tcSelect = 1'b0;
        expect_val(S_TC, 0, "tc_up_at_zero");

        // Load and clamp
        init_ld_en = 1'b1; ctrSelect = 3'd0; InitVal = 17'd5300;
        step(1);
        expect_val(S_SYNCH, 5300, "load_synch_5300");
        expect_val(S_COUNT, 5300, "load_count_5300");
        InitVal = 17'd12000;
        step(1);
        expect_val(S_SYNCH, 12000, "load_synch_12000");
        expect_val(S_COUNT, 9999,  "load_clamp_9999");
        expect_val(S_TC,    1,     "tc_at_9999");
        init_ld_en = 1'b0; InitVal = 17'd5;
        step(1);
        expect_val(S_SYNCH, 12000, "synch_holds");
        expect_val(S_COUNT, 9999,  "load_needs_enable");

        // Clear, count up, pause, phase retention
        ctrSelect = 3'd3;
        step(1);
        expect_val(S_COUNT, 0, "clear");
        ctrSelect = 3'd1; count_en = 1'b1;
        step(40);
        expect_val(S_COUNT, 10, "up_40clk");
        count_en = 1'b0;
        step(20);
        expect_val(S_COUNT, 10, "pause_20clk");
        count_en = 1'b1;
        step(2);
        count_en = 1'b0;
        step(5);
        count_en = 1'b1;
        step(1);
        expect_val(S_COUNT, 10, "phase_pre_tick");
        step(1);
        expect_val(S_COUNT, 11, "phase_tick");
        ctrSelect = 3'd0; count_en = 1'b0; InitVal = 17'd77;
        step(3);
        expect_val(S_COUNT, 11, "sel0_no_enable_hold");

        // Up saturation at 9999
        init_ld_en = 1'b1; ctrSelect = 3'd0; InitVal = 17'd9998;
        step(1);
        expect_val(S_COUNT, 9998, "load_9998");
        expect_val(S_TC,    0,    "tc_9998");
        init_ld_en = 1'b0; ctrSelect = 3'd1; count_en = 1'b1;
        step(3);
        expect_val(S_COUNT, 9998, "first_tick_not_early");
        step(1);
        expect_val(S_COUNT, 9999, "up_to_9999");
        expect_val(S_TC,    1,    "tc_up_reached");
        step(8);
        expect_val(S_COUNT, 9999, "up_saturate");

        // Down saturation at 0
        init_ld_en = 1'b1; ctrSelect = 3'd0; InitVal = 17'd2;
        step(1);
        init_ld_en = 1'b0; ctrSelect = 3'd2; tcSelect = 1'b1;
        step(4);
        expect_val(S_COUNT, 1, "down_to_1");
        expect_val(S_TC,    0, "tc_down_at_1");
        step(4);
        expect_val(S_COUNT, 0, "down_to_0");
        expect_val(S_TC,    1, "tc_down_reached");
        step(8);
        expect_val(S_COUNT, 0, "down_saturate");

        // Display scan of 1234
        init_ld_en = 1'b1; ctrSelect = 3'd0; InitVal = 17'd1234; count_en = 1'b0;
        step(1);
        init_ld_en = 1'b0; ctrSelect = 3'd4; anReset = 1'b1;
        step(1);
        expect_val(S_AN,   15,  "anreset_an");
        expect_val(S_SSEG, 127, "anreset_sseg");
        anReset = 1'b0;
        step(1);
        expect_val(S_AN,   'b1110,    "scan_an_ones");
        expect_val(S_SSEG, 'b0011001, "scan_sseg_4");
        step(4);
        expect_val(S_AN,   'b1101,    "scan_an_tens");
        expect_val(S_SSEG, 'b0110000, "scan_sseg_3");
        step(4);
        expect_val(S_AN,   'b1011,    "scan_an_hundreds");
        expect_val(S_SSEG, 'b0100100, "scan_sseg_2");
        step(4);
        expect_val(S_AN,   'b0111,    "scan_an_thousands");
        expect_val(S_SSEG, 'b1111001, "scan_sseg_1");
        step(4);
        expect_val(S_AN,   'b1110,    "scan_wrap_ones");
        anReset = 1'b1;
        step(1);
        expect_val(S_AN,    15,   "blank_an");
        expect_val(S_SSEG,  127,  "blank_sseg");
        expect_val(S_COUNT, 1234, "blank_count_kept");

        // Asynchronous reset in the middle of counting
        anReset = 1'b0; ctrSelect = 3'd1; count_en = 1'b1;
        step(2);
        expect_val(S_COUNT, 1234, "mid_count_1234");
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        expect_val(S_COUNT, 0,   "async_count");
        expect_val(S_SYNCH, 0,   "async_synch");
        expect_val(S_AN,    15,  "async_an");
        expect_val(S_SSEG,  127, "async_sseg");
        expect_val(S_TC,    1,   "async_tc");
        ->ev_sample;
        step(2);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
